// File: rtl/midi_note_decoder.sv
// midi_note_decoder
//   Byte-stream MIDI parser feeding the envelope generator. Decodes channel
//   Note On / Note Off messages (with running status) into single-cycle
//   strobes using monophonic, last-note semantics.
//
// Ports:
//   clk       in   system clock
//   rst_b     in   asynchronous active-low reset
//   rx_data   in   received MIDI byte
//   rx_valid  in   rx_data valid this cycle (1-cycle strobe)
//   note_on   out  1-cycle strobe: note started / retriggered
//   note_off  out  1-cycle strobe: held note released
//   note      out  note number of current/last note
//   velocity  out  velocity of last accepted Note On
//   gate      out  high while a note is held
//   msg_err   out  1-cycle strobe: message aborted or orphan data byte
module midi_note_decoder #(
    parameter int unsigned CHANNEL = 0,
    parameter int unsigned OMNI    = 0
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       note_on,
    output logic       note_off,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       gate,
    output logic       msg_err
);

    typedef enum logic [1:0] {
        WAIT_STATUS,
        WAIT_D1,
        WAIT_D2
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] rs, rs_nxt;              // running status, bit 7 implied
    logic       rs_valid, rs_valid_nxt;
    logic       discard, discard_nxt;    // inside system-common payload
    logic [6:0] d1, d1_nxt;
    logic [6:0] note_nxt, velocity_nxt;
    logic       gate_nxt, note_on_nxt, note_off_nxt, msg_err_nxt;

    logic       complete;
    logic [6:0] c_d1, c_d2;
    logic       ours, one_byte, is_note_kind;

    assign ours         = (OMNI != 0) || (rs[3:0] == 4'(CHANNEL));
    assign one_byte     = (rs[6:5] == 2'b10);   // 0xCn / 0xDn
    assign is_note_kind = (rs[6:5] == 2'b00);   // 0x8n / 0x9n

    always_comb begin
        state_nxt    = state;
        rs_nxt       = rs;
        rs_valid_nxt = rs_valid;
        discard_nxt  = discard;
        d1_nxt       = d1;
        note_nxt     = note;
        velocity_nxt = velocity;
        gate_nxt     = gate;
        note_on_nxt  = 1'b0;
        note_off_nxt = 1'b0;
        msg_err_nxt  = 1'b0;
        complete     = 1'b0;
        c_d1         = '0;
        c_d2         = '0;

        if (rx_valid) begin
            if (rx_data[7]) begin
                // Real-time bytes (0xF8-0xFF) fall through untouched.
                if (rx_data[7:3] != 5'b11111) begin
                    if (state != WAIT_STATUS) begin
                        msg_err_nxt = 1'b1;
                    end
                    if (rx_data[7:4] == 4'hF) begin
                        rs_valid_nxt = 1'b0;
                        discard_nxt  = 1'b1;
                        state_nxt    = WAIT_STATUS;
                    end else begin
                        rs_nxt       = rx_data[6:0];
                        rs_valid_nxt = 1'b1;
                        discard_nxt  = 1'b0;
                        state_nxt    = WAIT_D1;
                    end
                end
            end else begin
                case (state)
                    WAIT_STATUS: begin
                        if (rs_valid) begin
                            if (one_byte) begin
                                complete = 1'b1;
                                c_d1     = rx_data[6:0];
                            end else begin
                                d1_nxt    = rx_data[6:0];
                                state_nxt = WAIT_D2;
                            end
                        end else if (!discard) begin
                            msg_err_nxt = 1'b1;
                        end
                    end
                    WAIT_D1: begin
                        if (one_byte) begin
                            complete  = 1'b1;
                            c_d1      = rx_data[6:0];
                            state_nxt = WAIT_STATUS;
                        end else begin
                            d1_nxt    = rx_data[6:0];
                            state_nxt = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        complete  = 1'b1;
                        c_d1      = d1;
                        c_d2      = rx_data[6:0];
                        state_nxt = WAIT_STATUS;
                    end
                    default: state_nxt = WAIT_STATUS;
                endcase
            end
        end

        // One-byte messages never match is_note_kind, so c_d2 is only
        // meaningful for the two-byte completion path.
        if (complete && ours && is_note_kind) begin
            if (rs[4] && (c_d2 != '0)) begin
                note_nxt     = c_d1;
                velocity_nxt = c_d2;
                gate_nxt     = 1'b1;
                note_on_nxt  = 1'b1;
            end else if (gate && (c_d1 == note)) begin
                gate_nxt     = 1'b0;
                note_off_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= WAIT_STATUS;
            rs       <= '0;
            rs_valid <= 1'b0;
            discard  <= 1'b0;
            d1       <= '0;
            note     <= '0;
            velocity <= '0;
            gate     <= 1'b0;
            note_on  <= 1'b0;
            note_off <= 1'b0;
            msg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            rs       <= rs_nxt;
            rs_valid <= rs_valid_nxt;
            discard  <= discard_nxt;
            d1       <= d1_nxt;
            note     <= note_nxt;
            velocity <= velocity_nxt;
            gate     <= gate_nxt;
            note_on  <= note_on_nxt;
            note_off <= note_off_nxt;
            msg_err  <= msg_err_nxt;
        end
    end

endmodule

// File: tb/tb_midi_note_decoder.sv
// tb_midi_note_decoder
//   Table-driven bench: each record is one MIDI byte plus the outputs
//   expected on the cycle after it is accepted. Hand-written sequences
//   cover channel filtering (OMNI instance) and reset mid-message.
module tb_midi_note_decoder;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;

    logic       note_on, note_off, gate, msg_err;
    logic [6:0] note, velocity;
    logic       o_note_on, o_note_off, o_gate, o_msg_err;
    logic [6:0] o_note, o_velocity;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    midi_note_decoder #(.CHANNEL(0), .OMNI(0)) dut (
        .clk(clk), .rst_b(rst_b), .rx_data(rx_data), .rx_valid(rx_valid),
        .note_on(note_on), .note_off(note_off), .note(note),
        .velocity(velocity), .gate(gate), .msg_err(msg_err)
    );

    midi_note_decoder #(.CHANNEL(0), .OMNI(1)) dut_omni (
        .clk(clk), .rst_b(rst_b), .rx_data(rx_data), .rx_valid(rx_valid),
        .note_on(o_note_on), .note_off(o_note_off), .note(o_note),
        .velocity(o_velocity), .gate(o_gate), .msg_err(o_msg_err)
    );

    typedef struct {
        logic [7:0] b;
        logic       on;
        logic       off;
        logic [6:0] nt;
        logic [6:0] vel;
        logic       gt;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] b, input logic on, input logic off,
                       input int nt, input int vel, input logic gt, input logic err);
        vec_t v;
        v.b = b; v.on = on; v.off = off;
        v.nt = 7'(nt); v.vel = 7'(vel); v.gt = gt; v.err = err;
        vecs.push_back(v);
    endtask

    // Bytes are driven on the falling edge so consecutive calls give
    // rx_valid on back-to-back cycles; outputs are sampled #1 after posedge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic check(input string name, input logic on, input logic off,
                         input logic [6:0] nt, input logic [6:0] vel,
                         input logic gt, input logic err,
                         input logic a_on, input logic a_off,
                         input logic [6:0] a_nt, input logic [6:0] a_vel,
                         input logic a_gt, input logic a_err);
        tests++;
        if ({a_on, a_off, a_nt, a_vel, a_gt, a_err} !== {on, off, nt, vel, gt, err}) begin
            fails++;
            $display("FAIL %s: got on=%b off=%b note=%0d vel=%0d gate=%b err=%b, want on=%b off=%b note=%0d vel=%0d gate=%b err=%b",
                     name, a_on, a_off, a_nt, a_vel, a_gt, a_err, on, off, nt, vel, gt, err);
        end
    endtask

    initial begin
        // Scenario: basic note on / note off
        add(8'h90, 0, 0,  0,   0, 0, 0);
        add(8'h3C, 0, 0,  0,   0, 0, 0);
        add(8'h64, 1, 0, 60, 100, 1, 0);
        add(8'h80, 0, 0, 60, 100, 1, 0);
        add(8'h3C, 0, 0, 60, 100, 1, 0);
        add(8'h40, 0, 1, 60, 100, 0, 0);
        // Running status, retrigger, stale release
        add(8'h90, 0, 0, 60, 100, 0, 0);
        add(8'h3C, 0, 0, 60, 100, 0, 0);
        add(8'h64, 1, 0, 60, 100, 1, 0);
        add(8'h40, 0, 0, 60, 100, 1, 0);
        add(8'h50, 1, 0, 64,  80, 1, 0);
        add(8'h3C, 0, 0, 64,  80, 1, 0);
        add(8'h00, 0, 0, 64,  80, 1, 0);
        add(8'h40, 0, 0, 64,  80, 1, 0);
        add(8'h00, 0, 1, 64,  80, 0, 0);
        // Real-time bytes interleaved
        add(8'h90, 0, 0, 64,  80, 0, 0);
        add(8'hF8, 0, 0, 64,  80, 0, 0);
        add(8'h3C, 0, 0, 64,  80, 0, 0);
        add(8'hFE, 0, 0, 64,  80, 0, 0);
        add(8'h64, 1, 0, 60, 100, 1, 0);
        add(8'h80, 0, 0, 60, 100, 1, 0);
        add(8'h3C, 0, 0, 60, 100, 1, 0);
        add(8'h40, 0, 1, 60, 100, 0, 0);
        // Abort by new status, then a 1-byte program change
        add(8'h90, 0, 0, 60, 100, 0, 0);
        add(8'h3C, 0, 0, 60, 100, 0, 0);
        add(8'h80, 0, 0, 60, 100, 0, 1);
        add(8'h3C, 0, 0, 60, 100, 0, 0);
        add(8'h00, 0, 0, 60, 100, 0, 0);
        add(8'hC0, 0, 0, 60, 100, 0, 0);
        add(8'h05, 0, 0, 60, 100, 0, 0);
        add(8'h90, 0, 0, 60, 100, 0, 0);
        add(8'h45, 0, 0, 60, 100, 0, 0);
        add(8'h7F, 1, 0, 69, 127, 1, 0);
        add(8'h80, 0, 0, 69, 127, 1, 0);
        add(8'h45, 0, 0, 69, 127, 1, 0);
        add(8'h00, 0, 1, 69, 127, 0, 0);
        // SysEx: payload and trailing data discarded silently
        add(8'hF0, 0, 0, 69, 127, 0, 0);
        add(8'h7E, 0, 0, 69, 127, 0, 0);
        add(8'h3C, 0, 0, 69, 127, 0, 0);
        add(8'hF7, 0, 0, 69, 127, 0, 0);
        add(8'h3C, 0, 0, 69, 127, 0, 0);
        add(8'h64, 0, 0, 69, 127, 0, 0);
        // Fresh status after SysEx works; NOTE_OFF with any velocity releases
        add(8'h90, 0, 0, 69, 127, 0, 0);
        add(8'h3C, 0, 0, 69, 127, 0, 0);
        add(8'h64, 1, 0, 60, 100, 1, 0);
        add(8'h80, 0, 0, 60, 100, 1, 0);
        add(8'h3C, 0, 0, 60, 100, 1, 0);
        add(8'h00, 0, 1, 60, 100, 0, 0);

        // Reset state
        #1;
        check("reset_async", 0, 0, 0, 0, 0, 0,
              note_on, note_off, note, velocity, gate, msg_err);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 0, 0, 0, 0, 0, 0,
              note_on, note_off, note, velocity, gate, msg_err);

        for (int i = 0; i < vecs.size(); i++) begin
            send_byte(vecs[i].b);
            check($sformatf("vec%0d_byte%02h", i, vecs[i].b),
                  vecs[i].on, vecs[i].off, vecs[i].nt, vecs[i].vel, vecs[i].gt, vecs[i].err,
                  note_on, note_off, note, velocity, gate, msg_err);
        end

        // Channel filter: 0x91 is ignored by CHANNEL=0, accepted with OMNI=1
        send_byte(8'h91);
        send_byte(8'h3C);
        send_byte(8'h64);
        check("chan_filter", 0, 0, 60, 100, 0, 0,
              note_on, note_off, note, velocity, gate, msg_err);
        check("omni_on", 1, 0, 60, 100, 1, 0,
              o_note_on, o_note_off, o_note, o_velocity, o_gate, o_msg_err);
        @(posedge clk);
        #1;
        check("omni_strobe_width", 0, 0, 60, 100, 1, 0,
              o_note_on, o_note_off, o_note, o_velocity, o_gate, o_msg_err);

        // Reset mid-message: trailing data byte is an orphan
        send_byte(8'h90);
        send_byte(8'h3C);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("reset_mid_omni", 0, 0, 0, 0, 0, 0,
              o_note_on, o_note_off, o_note, o_velocity, o_gate, o_msg_err);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        send_byte(8'h64);
        check("orphan_after_reset", 0, 0, 0, 0, 0, 1,
              note_on, note_off, note, velocity, gate, msg_err);
        @(posedge clk);
        #1;
        check("err_strobe_width", 0, 0, 0, 0, 0, 0,
              note_on, note_off, note, velocity, gate, msg_err);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
